// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the phase-3 CPU control sequencer: opcodes, sequencer states,
// instruction classes and the last-execute-step lookup.
package cpu_ctrl_pkg;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_ROR  = 5'd7;
   localparam logic [4:0] OP_ROL  = 5'd8;
   localparam logic [4:0] OP_SHR  = 5'd9;
   localparam logic [4:0] OP_SHRA = 5'd10;
   localparam logic [4:0] OP_SHL  = 5'd11;
   localparam logic [4:0] OP_ADDI = 5'd12;
   localparam logic [4:0] OP_ANDI = 5'd13;
   localparam logic [4:0] OP_ORI  = 5'd14;
   localparam logic [4:0] OP_MUL  = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;
   localparam logic [4:0] OP_BR   = 5'd19;
   localparam logic [4:0] OP_JR   = 5'd20;
   localparam logic [4:0] OP_JAL  = 5'd21;
   localparam logic [4:0] OP_IN   = 5'd22;
   localparam logic [4:0] OP_OUT  = 5'd23;
   localparam logic [4:0] OP_MFHI = 5'd24;
   localparam logic [4:0] OP_MFLO = 5'd25;
   localparam logic [4:0] OP_NOP  = 5'd26;
   localparam logic [4:0] OP_HALT = 5'd27;

   localparam logic [4:0] ALU_ADD = 5'd3;

   localparam int CU_STATE_W = 6;

   typedef enum logic [CU_STATE_W-1:0] {
      ST_RESET = 6'd0,
      ST_T0    = 6'd1,
      ST_T1    = 6'd2,
      ST_T2    = 6'd3,
      ST_T3    = 6'd4,
      ST_T4    = 6'd5,
      ST_T5    = 6'd6,
      ST_T6    = 6'd7,
      ST_T7    = 6'd8,
      ST_HALT  = 6'd9,
      ST_PAUSE = 6'd10
   } state_e;

   typedef enum logic [3:0] {
      CLS_ALU_RR  = 4'd0,
      CLS_ALU_IMM = 4'd1,
      CLS_MULDIV  = 4'd2,
      CLS_UNARY   = 4'd3,
      CLS_LD      = 4'd4,
      CLS_LDI     = 4'd5,
      CLS_ST      = 4'd6,
      CLS_BR      = 4'd7,
      CLS_JR      = 4'd8,
      CLS_JAL     = 4'd9,
      CLS_IN      = 4'd10,
      CLS_OUT     = 4'd11,
      CLS_MFHI    = 4'd12,
      CLS_MFLO    = 4'd13,
      CLS_NOP     = 4'd14,
      CLS_HALT    = 4'd15
   } instr_cls_e;

   // Final execute step of each instruction class; after it the sequencer refetches.
   function automatic state_e last_step(input instr_cls_e cls);
      case (cls)
         CLS_ALU_RR, CLS_ALU_IMM, CLS_LDI: return ST_T5;
         CLS_MULDIV, CLS_BR:               return ST_T6;
         CLS_LD, CLS_ST:                   return ST_T7;
         CLS_UNARY, CLS_JAL:               return ST_T4;
         default:                          return ST_T3;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode-to-instruction-class decoder for the control sequencer.
module ctrl_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0] opcode,
   output logic [3:0] cls
);

   // Map each opcode onto the class that selects its execute-step sequence.
   always_comb begin
      cls = CLS_NOP;
      case (opcode) inside
         [OP_ADD:OP_SHL]:   cls = CLS_ALU_RR;
         [OP_ADDI:OP_ORI]:  cls = CLS_ALU_IMM;
         OP_MUL, OP_DIV:    cls = CLS_MULDIV;
         OP_NEG, OP_NOT:    cls = CLS_UNARY;
         OP_LD:             cls = CLS_LD;
         OP_LDI:            cls = CLS_LDI;
         OP_ST:             cls = CLS_ST;
         OP_BR:             cls = CLS_BR;
         OP_JR:             cls = CLS_JR;
         OP_JAL:            cls = CLS_JAL;
         OP_IN:             cls = CLS_IN;
         OP_OUT:            cls = CLS_OUT;
         OP_MFHI:           cls = CLS_MFHI;
         OP_MFLO:           cls = CLS_MFLO;
         OP_HALT:           cls = CLS_HALT;
         default:           cls = CLS_NOP;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch T0..T2, per-class execute T3..T7, memory wait, HALT.
// Optional SINGLE_STEP_EN adds the step input and a PAUSE state after every instruction.
module control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 0,
   parameter int STATE_W  = 6
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        CON,
   input  logic        stop,
`ifdef SINGLE_STEP_EN
   input  logic        step,
`endif
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        R15in,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        memRead,
   output logic        ramEnable,
   output logic        PCin,
   output logic        PCout,
   output logic        IncPC,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        HIin,
   output logic        LOin,
   output logic        HIout,
   output logic        LOout,
   output logic        Cout,
   output logic        CONin,
   output logic        InPort_Out,
   output logic        OutPort_In,
   output logic [4:0]  alu_op,
   output logic        run
);

   localparam int WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT);

   logic [STATE_W-1:0] state_r;
   logic [WAIT_W-1:0]  wait_r;
   logic [4:0]         op_r;
   instr_cls_e         cls_r;
   state_e             cur_s;
   state_e             nxt_s;
   state_e             done_s;
   logic [3:0]         dec_cls_s;
   instr_cls_e         ir_cls_s;
   logic               unused_ir_s;

   assign cur_s       = state_e'(state_r[CU_STATE_W-1:0]);
   assign ir_cls_s    = instr_cls_e'(dec_cls_s);
   assign unused_ir_s = ^ir[26:0];

   ctrl_decoder u_dec (
      .opcode (ir[31:27]),
      .cls    (dec_cls_s)
   );

   function automatic logic is_mem(input state_e s, input instr_cls_e c);
      return (s == ST_T1) || (s == ST_T6 && c == CLS_LD) || (s == ST_T7 && c == CLS_ST);
   endfunction

   // Next-state selection; memory steps hold until the wait counter reaches zero.
   always_comb begin
      nxt_s = cur_s;
`ifdef SINGLE_STEP_EN
      done_s = ST_PAUSE;
`else
      done_s = ST_T0;
`endif
      case (cur_s)
         ST_RESET: nxt_s = ST_T0;
         ST_T0: begin
            if (stop) nxt_s = ST_HALT;
            else      nxt_s = ST_T1;
         end
         ST_T1: begin
            if (wait_r != '0) nxt_s = ST_T1;
            else              nxt_s = ST_T2;
         end
         ST_T2: begin
            case (ir_cls_s)
               CLS_NOP:  nxt_s = done_s;
               CLS_HALT: nxt_s = ST_HALT;
               default:  nxt_s = ST_T3;
            endcase
         end
         ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
            if (is_mem(cur_s, cls_r) && wait_r != '0)             nxt_s = cur_s;
            else if (cur_s == last_step(cls_r) || cur_s == ST_T7) nxt_s = done_s;
            else                                                  nxt_s = state_e'(cur_s + 6'd1);
         end
         ST_HALT: nxt_s = ST_HALT;
`ifdef SINGLE_STEP_EN
         ST_PAUSE: begin
            if (step) nxt_s = ST_T0;
            else      nxt_s = ST_PAUSE;
         end
`endif
         default: nxt_s = ST_RESET;
      endcase
   end

   // State, wait counter and opcode/class latch (captured at the closing edge of T2).
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_r <= STATE_W'(ST_RESET);
         wait_r  <= '0;
         op_r    <= 5'd0;
         cls_r   <= CLS_NOP;
      end else begin
         state_r <= STATE_W'(nxt_s);
         if (nxt_s != cur_s && is_mem(nxt_s, cls_r)) wait_r <= WAIT_LOAD;
         else if (wait_r != '0)                       wait_r <= wait_r - WAIT_W'(1);
         else                                         wait_r <= wait_r;
         if (cur_s == ST_T2) begin
            op_r  <= ir[31:27];
            cls_r <= ir_cls_s;
         end
      end
   end

   // Moore strobe decode of the current step; br's PCin follows CON live during T6.
   always_comb begin
      {Gra, Grb, Grc, Rin, Rout, BAout, R15in} = 7'd0;
      {MARin, MDRin, MDRout, memRead, ramEnable} = 5'd0;
      {PCin, PCout, IncPC, IRin} = 4'd0;
      {Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, CONin} = 10'd0;
      {InPort_Out, OutPort_In} = 2'd0;
      alu_op = 5'd0;
      if (cur_s == ST_RESET || cur_s == ST_HALT) run = 1'b0;
      else                                       run = 1'b1;
      case (cur_s)
         ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
         ST_T1: begin memRead = 1'b1; MDRin = 1'b1; end
         ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         ST_T3: begin
            case (cls_r)
               CLS_ALU_RR, CLS_ALU_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               CLS_MULDIV:              begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               CLS_UNARY:               begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_r; end
               CLS_LD, CLS_LDI, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
               CLS_BR:                  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
               CLS_JR:                  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               CLS_JAL:                 begin PCout = 1'b1; R15in = 1'b1; end
               CLS_IN:                  begin InPort_Out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               CLS_OUT:                 begin Gra = 1'b1; Rout = 1'b1; OutPort_In = 1'b1; end
               CLS_MFHI:                begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               CLS_MFLO:                begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               default:                 alu_op = 5'd0;
            endcase
         end
         ST_T4: begin
            case (cls_r)
               CLS_ALU_RR:              begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_r; end
               CLS_ALU_IMM:             begin Cout = 1'b1; Zin = 1'b1; alu_op = op_r; end
               CLS_MULDIV:              begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_r; end
               CLS_UNARY:               begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               CLS_LD, CLS_LDI, CLS_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
               CLS_BR:                  begin PCout = 1'b1; Yin = 1'b1; end
               CLS_JAL:                 begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               default:                 alu_op = 5'd0;
            endcase
         end
         ST_T5: begin
            case (cls_r)
               CLS_ALU_RR, CLS_ALU_IMM, CLS_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               CLS_MULDIV:                       begin Zlowout = 1'b1; LOin = 1'b1; end
               CLS_LD, CLS_ST:                   begin Zlowout = 1'b1; MARin = 1'b1; end
               CLS_BR:                           begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
               default:                          alu_op = 5'd0;
            endcase
         end
         ST_T6: begin
            case (cls_r)
               CLS_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
               CLS_LD:     begin memRead = 1'b1; MDRin = 1'b1; end
               CLS_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
               CLS_BR:     begin Zlowout = 1'b1; PCin = CON; end
               default:    alu_op = 5'd0;
            endcase
         end
         ST_T7: begin
            case (cls_r)
               CLS_LD:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               CLS_ST:  ramEnable = 1'b1;
               default: alu_op = 5'd0;
            endcase
         end
         default: alu_op = 5'd0;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle strobe trace compared against a
// table-driven model of each instruction's step list; directed cases then random ones.
module tb_control_unit;

   localparam int TB_MEM_WAIT = 2;

   localparam logic [27:0] M_GRA   = 28'd1 << 27;
   localparam logic [27:0] M_GRB   = 28'd1 << 26;
   localparam logic [27:0] M_GRC   = 28'd1 << 25;
   localparam logic [27:0] M_RIN   = 28'd1 << 24;
   localparam logic [27:0] M_ROUT  = 28'd1 << 23;
   localparam logic [27:0] M_BAOUT = 28'd1 << 22;
   localparam logic [27:0] M_R15IN = 28'd1 << 21;
   localparam logic [27:0] M_MARIN = 28'd1 << 20;
   localparam logic [27:0] M_MDRIN = 28'd1 << 19;
   localparam logic [27:0] M_MDROUT= 28'd1 << 18;
   localparam logic [27:0] M_MEMRD = 28'd1 << 17;
   localparam logic [27:0] M_RAMEN = 28'd1 << 16;
   localparam logic [27:0] M_PCIN  = 28'd1 << 15;
   localparam logic [27:0] M_PCOUT = 28'd1 << 14;
   localparam logic [27:0] M_INCPC = 28'd1 << 13;
   localparam logic [27:0] M_IRIN  = 28'd1 << 12;
   localparam logic [27:0] M_YIN   = 28'd1 << 11;
   localparam logic [27:0] M_ZIN   = 28'd1 << 10;
   localparam logic [27:0] M_ZHI   = 28'd1 << 9;
   localparam logic [27:0] M_ZLO   = 28'd1 << 8;
   localparam logic [27:0] M_HIIN  = 28'd1 << 7;
   localparam logic [27:0] M_LOIN  = 28'd1 << 6;
   localparam logic [27:0] M_HIOUT = 28'd1 << 5;
   localparam logic [27:0] M_LOOUT = 28'd1 << 4;
   localparam logic [27:0] M_COUT  = 28'd1 << 3;
   localparam logic [27:0] M_CONIN = 28'd1 << 2;
   localparam logic [27:0] M_INP   = 28'd1 << 1;
   localparam logic [27:0] M_OUTP  = 28'd1 << 0;

   logic clock = 1'b0;
   logic clear, CON, stop;
   logic [31:0] ir;
`ifdef SINGLE_STEP_EN
   logic step = 1'b1;
`endif
   logic Gra, Grb, Grc, Rin, Rout, BAout, R15in;
   logic MARin, MDRin, MDRout, memRead, ramEnable;
   logic PCin, PCout, IncPC, IRin;
   logic Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, CONin;
   logic InPort_Out, OutPort_In, run;
   logic [4:0] alu_op;

   int checks = 0;
   int errors = 0;
   logic [33:0] exp_q[$];

   control_unit #(.MEM_WAIT(TB_MEM_WAIT), .STATE_W(6)) dut (
      .clock(clock), .clear(clear), .ir(ir), .CON(CON), .stop(stop),
`ifdef SINGLE_STEP_EN
      .step(step),
`endif
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .R15in(R15in),
      .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .memRead(memRead), .ramEnable(ramEnable),
      .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin),
      .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin),
      .HIout(HIout), .LOout(LOout), .Cout(Cout), .CONin(CONin),
      .InPort_Out(InPort_Out), .OutPort_In(OutPort_In), .alu_op(alu_op), .run(run)
   );

   always #5 clock = ~clock;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [33:0] observed();
      return {run, alu_op, Gra, Grb, Grc, Rin, Rout, BAout, R15in, MARin, MDRin, MDRout,
              memRead, ramEnable, PCin, PCout, IncPC, IRin, Yin, Zin, Zhighout, Zlowout,
              HIin, LOin, HIout, LOout, Cout, CONin, InPort_Out, OutPort_In};
   endfunction

   task automatic check(input string tag, input logic [33:0] got, input logic [33:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic push(input logic [27:0] m, input logic [4:0] a, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back({1'b1, a, m});
   endtask

   task automatic push_idle(input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(34'd0);
   endtask

   // Expected per-cycle trace of one instruction, written from its step list.
   task automatic build(input logic [31:0] instr, input logic con, input logic stp);
      int op;
      logic [4:0] opc;
      op  = int'(instr[31:27]);
      opc = instr[31:27];
      exp_q.delete();
      push(M_PCOUT | M_MARIN | M_INCPC, 5'd0, 1);
      if (stp) begin
         push_idle(3);
         return;
      end
      push(M_MEMRD | M_MDRIN, 5'd0, TB_MEM_WAIT + 1);
      push(M_MDROUT | M_IRIN, 5'd0, 1);
      if (op >= 3 && op <= 11) begin
         push(M_GRB | M_ROUT | M_YIN, 5'd0, 1);
         push(M_GRC | M_ROUT | M_ZIN, opc, 1);
         push(M_ZLO | M_GRA | M_RIN, 5'd0, 1);
      end else if (op >= 12 && op <= 14) begin
         push(M_GRB | M_ROUT | M_YIN, 5'd0, 1);
         push(M_COUT | M_ZIN, opc, 1);
         push(M_ZLO | M_GRA | M_RIN, 5'd0, 1);
      end else if (op == 15 || op == 16) begin
         push(M_GRA | M_ROUT | M_YIN, 5'd0, 1);
         push(M_GRB | M_ROUT | M_ZIN, opc, 1);
         push(M_ZLO | M_LOIN, 5'd0, 1);
         push(M_ZHI | M_HIIN, 5'd0, 1);
      end else if (op == 17 || op == 18) begin
         push(M_GRB | M_ROUT | M_ZIN, opc, 1);
         push(M_ZLO | M_GRA | M_RIN, 5'd0, 1);
      end else if (op <= 2) begin
         push(M_GRB | M_BAOUT | M_YIN, 5'd0, 1);
         push(M_COUT | M_ZIN, 5'd3, 1);
         if (op == 1) push(M_ZLO | M_GRA | M_RIN, 5'd0, 1);
         else         push(M_ZLO | M_MARIN, 5'd0, 1);
         if (op == 0) begin
            push(M_MEMRD | M_MDRIN, 5'd0, TB_MEM_WAIT + 1);
            push(M_MDROUT | M_GRA | M_RIN, 5'd0, 1);
         end else if (op == 2) begin
            push(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1);
            push(M_RAMEN, 5'd0, TB_MEM_WAIT + 1);
         end
      end else if (op == 19) begin
         push(M_GRA | M_ROUT | M_CONIN, 5'd0, 1);
         push(M_PCOUT | M_YIN, 5'd0, 1);
         push(M_COUT | M_ZIN, 5'd3, 1);
         push(M_ZLO | (con ? M_PCIN : 28'd0), 5'd0, 1);
      end else if (op == 20) push(M_GRA | M_ROUT | M_PCIN, 5'd0, 1);
      else if (op == 21) begin
         push(M_PCOUT | M_R15IN, 5'd0, 1);
         push(M_GRA | M_ROUT | M_PCIN, 5'd0, 1);
      end else if (op == 22) push(M_INP | M_GRA | M_RIN, 5'd0, 1);
      else if (op == 23) push(M_GRA | M_ROUT | M_OUTP, 5'd0, 1);
      else if (op == 24) push(M_HIOUT | M_GRA | M_RIN, 5'd0, 1);
      else if (op == 25) push(M_LOOUT | M_GRA | M_RIN, 5'd0, 1);
      else if (op == 27) begin
         push_idle(20);
         return;
      end
`ifdef SINGLE_STEP_EN
      push(28'd0, 5'd0, 1);
`endif
   endtask

   // Entered one tick after a negedge with the DUT in T0; leaves the same way unless
   // upto >= 0, in which case it stops right after checking entry upto.
   task automatic run_instr(input logic [31:0] instr, input logic con, input logic stp,
                            input int upto, input string name);
      int last;
      build(instr, con, stp);
      ir   = instr;
      CON  = con;
      stop = stp;
      last = (upto < 0) ? exp_q.size() - 1 : upto;
      for (int i = 0; i <= last; i++) begin
         check($sformatf("%s[%0d] ir=%h", name, i, instr), observed(), exp_q[i]);
         if (upto < 0 || i < last) begin
            @(negedge clock);
            #1;
         end
      end
      stop = 1'b0;
   endtask

   // Clear pulse: outputs drop at once, stay idle through RESET, then T0 after release.
   task automatic do_reset(input string name);
      clear = 1'b0;
      #1;
      check({name, "_async"}, observed(), 34'd0);
      @(negedge clock);
      #1;
      check({name, "_hold"}, observed(), 34'd0);
      clear = 1'b1;
      #1;
      check({name, "_reset_state"}, observed(), 34'd0);
      @(negedge clock);
      #1;
   endtask

   initial begin
      logic [31:0] rnd_ir;
      logic        rnd_con, rnd_stop;
      clear = 1'b0;
      CON   = 1'b0;
      stop  = 1'b0;
      ir    = 32'd0;
      @(negedge clock);
      #1;
      do_reset("init");

      run_instr(32'hA300_0000, 1'b0, 1'b0, -1, "jr");
      run_instr(32'h1891_8000, 1'b0, 1'b0, -1, "add");
      run_instr(32'h0088_0010, 1'b0, 1'b0, -1, "ld");
      run_instr(32'h9880_0004, 1'b0, 1'b0, -1, "br_con0");
      run_instr(32'h9880_0004, 1'b1, 1'b0, -1, "br_con1");
      run_instr(32'h7910_0000, 1'b0, 1'b0, -1, "mul");
      run_instr(32'hA880_0000, 1'b0, 1'b0, -1, "jal");
      run_instr(32'h6110_0005, 1'b0, 1'b0, -1, "addi");
      run_instr(32'hD000_0000, 1'b0, 1'b0, -1, "nop");
      run_instr(32'h1088_0020, 1'b0, 1'b0, TB_MEM_WAIT + 7, "st_abort");
      do_reset("st_clear");
      run_instr(32'h1891_8000, 1'b0, 1'b0, -1, "after_abort");
      run_instr(32'h1891_8000, 1'b0, 1'b1, -1, "stop");
      do_reset("stop_clear");
      run_instr(32'hD800_0000, 1'b0, 1'b0, -1, "halt");
      do_reset("halt_clear");

      for (int n = 0; n < 120; n++) begin
         rnd_ir   = $urandom;
         rnd_con  = 1'($urandom_range(0, 1));
         rnd_stop = ($urandom_range(0, 11) == 0);
         run_instr(rnd_ir, rnd_con, rnd_stop, -1, "rnd");
         if (rnd_stop || rnd_ir[31:27] == 5'd27) do_reset("rnd_clear");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
